// File: rtl/resizer_pkg.sv
// Shared definitions for the resizer lane buffers: lane field layout and entry sizing.
package resizer_pkg;

    localparam int KEEP_BIT = 0;
    localparam int LAST_BIT = 1;
    localparam int DATA_LSB = 2;

    // Packed so that keep lands on bit 0 and last on bit 1 of a lane field.
    typedef struct packed {
        logic last;
        logic keep;
    } lane_flags_t;

    function automatic int entry_sz(input int data_w, input int lanes);
        return (DATA_LSB + data_w) * lanes;
    endfunction

endpackage

// File: rtl/lane_compactor.sv
// Packs the kept lanes of one slave entry down to the low lane indices, in order.
module lane_compactor
    import resizer_pkg::*;
#(
    parameter int S_KEEP_WIDTH = 3,
    parameter int T_DATA_WIDTH = 1,
    parameter int EW           = entry_sz(T_DATA_WIDTH, S_KEEP_WIDTH),
    parameter int CW           = $clog2(S_KEEP_WIDTH + 1)
) (
    input  logic [EW-1:0] entry,
    output logic [EW-1:0] packed_entry,
    output logic [CW-1:0] kept_count
);
    localparam int LW = DATA_LSB + T_DATA_WIDTH;

    // pos is the running prefix sum of keep bits below lane i.
    always_comb begin
        int pos;
        pos          = 0;
        packed_entry = '0;
        for (int i = 0; i < S_KEEP_WIDTH; i++) begin
            if (entry[i*LW + KEEP_BIT]) begin
                packed_entry[pos*LW +: LW] = entry[i*LW +: LW];
                pos = pos + 1;
            end
        end
        kept_count = CW'(pos);
    end

endmodule

// File: rtl/out_lane_buffer.sv
// Circular lane store that re-slices slave-width entries into master-width entries.
module out_lane_buffer
    import resizer_pkg::*;
#(
    parameter int S_KEEP_WIDTH     = 3,
    parameter int T_DATA_WIDTH     = 1,
    parameter int M_KEEP_WIDTH     = 2,
    parameter int DEPTH            = 8,
    parameter int BUF_IN_ENTRY_SZ  = entry_sz(T_DATA_WIDTH, S_KEEP_WIDTH),
    parameter int BUF_OUT_ENTRY_SZ = entry_sz(T_DATA_WIDTH, M_KEEP_WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BUF_IN_ENTRY_SZ-1:0]  s_entry,
    input  logic                        s_entry_valid,
    output logic                        s_entry_ready,
    output logic [BUF_OUT_ENTRY_SZ-1:0] master_entry,
    output logic                        underflow,
    input  logic                        master_entry_ready,
    output logic [$clog2(DEPTH):0]      occupancy
);
    localparam int LW = DATA_LSB + T_DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(S_KEEP_WIDTH + 1);

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        lane_flags_t             flags;
    } lane_t;

    lane_t [DEPTH-1:0]        store;
    logic  [AW-1:0]           wr_ptr, rd_ptr;
    logic  [BUF_IN_ENTRY_SZ-1:0] packed_entry;
    logic  [CW-1:0]           kept_count;
    lane_t [M_KEEP_WIDTH-1:0] win, head;
    logic  [OW-1:0]           pop_cnt;
    logic                     found, avail, push, pop;

    lane_compactor #(
        .S_KEEP_WIDTH (S_KEEP_WIDTH),
        .T_DATA_WIDTH (T_DATA_WIDTH)
    ) u_compact (
        .entry        (s_entry),
        .packed_entry (packed_entry),
        .kept_count   (kept_count)
    );

    assign s_entry_ready = occupancy <= OW'(DEPTH - S_KEEP_WIDTH);
    assign push          = s_entry_valid & s_entry_ready;
    assign pop           = master_entry_ready & avail;
    assign underflow     = !avail;
    assign master_entry  = head;

    // Window slots beyond occupancy hold stale lanes, so the last search is gated by occupancy.
    always_comb begin
        found   = 1'b0;
        pop_cnt = OW'(M_KEEP_WIDTH);
        head    = '0;
        for (int j = 0; j < M_KEEP_WIDTH; j++) begin
            win[j] = store[rd_ptr + AW'(j)];
            if (!found && OW'(j) < occupancy && win[j].flags.last) begin
                found   = 1'b1;
                pop_cnt = OW'(j + 1);
            end
        end
        avail = found || occupancy >= OW'(M_KEEP_WIDTH);
        for (int j = 0; j < M_KEEP_WIDTH; j++) begin
            if (avail && OW'(j) < pop_cnt) begin
                head[j]            = win[j];
                head[j].flags.keep = 1'b1;
                head[j].flags.last = found && OW'(j + 1) == pop_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < S_KEEP_WIDTH; i++) begin
                    if (CW'(i) < kept_count)
                        store[wr_ptr + AW'(i)] <= lane_t'(packed_entry[i*LW +: LW]);
                end
                wr_ptr <= wr_ptr + AW'(kept_count);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(pop_cnt);
            occupancy <= occupancy + (push ? OW'(kept_count) : OW'(0))
                                   - (pop  ? pop_cnt        : OW'(0));
        end
    end

endmodule

// File: tb/tb_out_lane_buffer.sv
// Scoreboard bench for out_lane_buffer with S=3, M=2, W=8, DEPTH=8.
module tb_out_lane_buffer;
    localparam int S = 3, M = 2, W = 8, D = 8, LW = W + 2;

    logic            clk = 0;
    logic            rst_n = 0;
    logic [S*LW-1:0] s_entry = '0;
    logic            s_entry_valid = 0;
    logic            s_entry_ready;
    logic [M*LW-1:0] master_entry;
    logic            underflow;
    logic            master_entry_ready = 0;
    logic [3:0]      occupancy;

    out_lane_buffer #(.S_KEEP_WIDTH(S), .T_DATA_WIDTH(W), .M_KEEP_WIDTH(M), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .s_entry(s_entry), .s_entry_valid(s_entry_valid),
        .s_entry_ready(s_entry_ready), .master_entry(master_entry), .underflow(underflow),
        .master_entry_ready(master_entry_ready), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] d; logic l; } mlane_t;
    mlane_t          mq[$];
    logic [M*LW-1:0] exp_q[$];
    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] ln(input logic [W-1:0] d, input logic l, input logic k);
        return {d, l, k};
    endfunction

    // Reference: a plain queue of stored lanes; an output entry is the first lanes up to a last.
    task automatic model_out(output logic av, output logic [M*LW-1:0] e, output int cnt);
        int n;
        n = -1; e = '0; cnt = 0;
        for (int j = 0; j < M && j < mq.size(); j++)
            if (n < 0 && mq[j].l) n = j;
        if (n >= 0) cnt = n + 1;
        else if (mq.size() >= M) cnt = M;
        av = cnt > 0;
        for (int j = 0; j < cnt; j++) e[j*LW +: LW] = ln(mq[j].d, j == n, 1'b1);
    endtask

    task automatic step(input logic v, input logic [S*LW-1:0] ent, input logic rdy);
        logic av; logic [M*LW-1:0] e; int cnt, sz0;
        @(negedge clk); #1;
        sz0 = mq.size();
        model_out(av, e, cnt);
        chk("occupancy", 32'(occupancy), 32'(sz0));
        chk("s_entry_ready", 32'(s_entry_ready), 32'((D - sz0) >= S));
        chk("underflow", 32'(underflow), 32'(!av));
        s_entry_valid = v; s_entry = ent; master_entry_ready = rdy;
        if (rdy && av) begin
            exp_q.push_back(e);
            repeat (cnt) void'(mq.pop_front());
        end
        if (v && (D - sz0) >= S)
            for (int i = 0; i < S; i++)
                if (ent[i*LW]) mq.push_back('{ent[i*LW+2 +: W], ent[i*LW+1]});
    endtask

    task automatic drain();
        for (int k = 0; k < 12 && mq.size() > 0; k++) begin
            if (mq.size() == 1 && !mq[0].l) step(1, {{(2*LW){1'b0}}, ln(8'hEE, 1, 1)}, 1);
            else step(0, '0, 1);
        end
        step(0, '0, 0);
    endtask

    task automatic do_reset_mid();
        @(negedge clk); #1;
        rst_n = 0; s_entry_valid = 0; master_entry_ready = 0;
        #1;
        chk("rst_occupancy", 32'(occupancy), 0);
        chk("rst_underflow", 32'(underflow), 1);
        chk("rst_master_entry", 32'(master_entry), 0);
        mq.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1;
    endtask

    // Monitor: consumes an expected entry whenever the DUT hands one over.
    initial forever begin
        @(negedge clk); #2;
        if (rst_n && master_entry_ready && !underflow) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_pop: got %h expected none", master_entry);
            end else chk("master_entry", 32'(master_entry), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [S*LW-1:0] full_a, full_b, ent;
        full_a = {ln(8'hA2, 0, 1), ln(8'hA1, 0, 1), ln(8'hA0, 0, 1)};
        full_b = {ln(8'hB2, 1, 1), ln(8'hB1, 0, 1), ln(8'hB0, 0, 1)};

        s_entry_valid = 1; s_entry = full_a;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_underflow", 32'(underflow), 1);
        chk("reset_master_entry", 32'(master_entry), 0);
        chk("reset_ready", 32'(s_entry_ready), 1);
        chk("reset_occupancy", 32'(occupancy), 0);
        s_entry_valid = 0;
        rst_n = 1;

        // continuous packet
        step(1, full_a, 1);
        step(1, full_b, 1);
        repeat (4) step(0, '0, 1);
        step(0, '0, 0);

        // sparse keep
        step(1, {ln(8'h33, 0, 1), ln(8'h22, 0, 0), ln(8'h11, 0, 1)}, 0);
        step(0, '0, 0);
        chk("sparse_entry", 32'(master_entry), 32'({ln(8'h33, 0, 1), ln(8'h11, 0, 1)}));
        drain();

        // short tail
        step(1, {ln(8'h00, 0, 0), ln(8'h00, 0, 0), ln(8'h5A, 1, 1)}, 0);
        step(0, '0, 0);
        chk("tail_entry", 32'(master_entry), 32'({{LW{1'b0}}, ln(8'h5A, 1, 1)}));
        step(0, '0, 1);
        step(0, '0, 0);

        // full and back-pressure
        step(1, full_a, 0);
        step(1, full_a, 0);
        step(1, full_a, 1);
        step(0, '0, 0);
        drain();

        // concurrency then mid-packet reset
        step(1, full_a, 0);
        step(1, {ln(8'h00, 0, 0), ln(8'h00, 0, 0), ln(8'h77, 0, 1)}, 0);
        step(1, full_a, 1);
        step(0, '0, 0);
        chk("concurrent_occupancy", 32'(occupancy), 5);
        do_reset_mid();
        step(0, '0, 0);

        // random traffic
        for (int t = 0; t < 2000; t++) begin
            ent = '0;
            for (int i = 0; i < S; i++) begin
                logic k;
                k = $urandom_range(0, 2) != 0;
                ent[i*LW +: LW] = ln(8'($urandom), k && ($urandom_range(0, 3) == 0), k);
            end
            step($urandom_range(0, 3) != 0, ent, $urandom_range(0, 2) != 0);
        end
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
